// File: rtl/led_ctrl_pkg.sv
// Shared mode encoding for the LED pattern controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  function automatic logic mode_runs(mode_e m);
    return (m == MODE_BLINK) || (m == MODE_BURST);
  endfunction

endpackage

// File: rtl/led_chan.sv
// One LED channel: mode, phase and burst counters, lit/busy flags, registered LED.
// Optional per-channel duty gating when LED_PWM_EN is defined.
module led_chan
  import led_ctrl_pkg::*;
#(
  parameter int HALF_W  = 10,
  parameter int BURST_W = 4
`ifdef LED_PWM_EN
  ,
  parameter int PWM_W   = 4
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tick_i,
  input  logic               we_i,
  input  mode_e              mode_i,
  input  logic [HALF_W-1:0]  half_i,
  input  logic [BURST_W-1:0] count_i,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]   duty_i,
  input  logic [PWM_W-1:0]   pwm_i,
`endif
  output logic               led_o,
  output logic               busy_o
);

  localparam logic [HALF_W-1:0]  HALF_ONE  = HALF_W'(1);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  mode_e              mode_q, mode_d;
  logic [HALF_W-1:0]  half_q, half_d;
  logic [HALF_W-1:0]  phase_q, phase_d;
  logic [BURST_W-1:0] count_q, count_d;
  logic [BURST_W-1:0] falls_q, falls_d;
  logic               lit_q, lit_d;
  logic               busy_q, busy_d;
  logic               led_q, led_d;
`ifdef LED_PWM_EN
  logic [PWM_W-1:0]   duty_q, duty_d;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q  <= MODE_OFF;
      half_q  <= HALF_ONE;
      phase_q <= '0;
      count_q <= '0;
      falls_q <= '0;
      lit_q   <= 1'b0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
`ifdef LED_PWM_EN
      duty_q  <= '1;
`endif
    end else begin
      mode_q  <= mode_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      count_q <= count_d;
      falls_q <= falls_d;
      lit_q   <= lit_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
`ifdef LED_PWM_EN
      duty_q  <= duty_d;
`endif
    end
  end

  always_comb begin
    mode_d  = mode_q;
    half_d  = half_q;
    phase_d = phase_q;
    count_d = count_q;
    falls_d = falls_q;
    lit_d   = lit_q;
    busy_d  = busy_q;
`ifdef LED_PWM_EN
    duty_d  = duty_q;
`endif

    // A write takes priority over a coincident tick; that tick is dropped.
    if (we_i) begin
      mode_d  = mode_i;
      half_d  = (half_i == '0) ? HALF_ONE : half_i;
      count_d = count_i;
      phase_d = '0;
      falls_d = '0;
      lit_d   = (mode_i == MODE_ON);
      busy_d  = 1'b0;
`ifdef LED_PWM_EN
      duty_d  = duty_i;
`endif
      if (mode_i == MODE_BURST) begin
        if (count_i == '0) mode_d = MODE_OFF;
        else               busy_d = 1'b1;
      end
    end else if (tick_i && mode_runs(mode_q)) begin
      if (phase_q == half_q - HALF_ONE) begin
        phase_d = '0;
        lit_d   = ~lit_q;
        if (mode_q == MODE_BURST && lit_q) begin
          falls_d = falls_q + BURST_ONE;
          if (falls_q == count_q - BURST_ONE) begin
            mode_d = MODE_OFF;
            busy_d = 1'b0;
          end
        end
      end else begin
        phase_d = phase_q + HALF_ONE;
      end
    end

`ifdef LED_PWM_EN
    led_d = lit_q & ((&duty_q) | (pwm_i < duty_q));
`else
    led_d = lit_q;
`endif
  end

  assign led_o  = led_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern generator: shared tick prescaler, config write decode,
// NCH led_chan instances. Optional PWM brightness when LED_PWM_EN is defined.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int PRESCALE = 27000,
  parameter int HALF_W   = 10,
  parameter int BURST_W  = 4,
`ifdef LED_PWM_EN
  parameter int PWM_W    = 4,
`endif
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               iCfgValid,
  input  logic [CH_W-1:0]    iCfgCh,
  input  logic [1:0]         iCfgMode,
  input  logic [HALF_W-1:0]  iCfgHalf,
  input  logic [BURST_W-1:0] iCfgCount,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]   iCfgDuty,
`endif
  output logic               oCfgReady,
  output logic [NCH-1:0]     oLED,
  output logic [NCH-1:0]     oBusy
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             ready_q;
  logic             tick;
  logic             cfg_acc;
`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_q, pwm_d;
`endif

  assign tick    = (pre_q == PRE_W'(PRESCALE - 1));
  assign pre_d   = tick ? '0 : pre_q + PRE_W'(1);
  assign cfg_acc = iCfgValid & ready_q;
`ifdef LED_PWM_EN
  assign pwm_d   = pwm_q + PWM_W'(1);
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre_q   <= '0;
      ready_q <= 1'b0;
`ifdef LED_PWM_EN
      pwm_q   <= '0;
`endif
    end else begin
      pre_q   <= pre_d;
      ready_q <= 1'b1;
`ifdef LED_PWM_EN
      pwm_q   <= pwm_d;
`endif
    end
  end

  assign oCfgReady = ready_q;

  // Channel numbers with no matching instance decode to nothing, so they are ignored.
  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic we;
    assign we = cfg_acc && (iCfgCh == CH_W'(g));

    led_chan #(
      .HALF_W  (HALF_W),
      .BURST_W (BURST_W)
`ifdef LED_PWM_EN
      ,
      .PWM_W   (PWM_W)
`endif
    ) u_chan (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .tick_i  (tick),
      .we_i    (we),
      .mode_i  (mode_e'(iCfgMode)),
      .half_i  (iCfgHalf),
      .count_i (iCfgCount),
`ifdef LED_PWM_EN
      .duty_i  (iCfgDuty),
      .pwm_i   (pwm_q),
`endif
      .led_o   (oLED[g]),
      .busy_o  (oBusy[g])
    );
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed and random config writes checked every cycle
// against a tick-count reference model. Define LED_PWM_EN to exercise brightness.
module tb_led_pattern_ctrl;

  localparam int NCH      = 4;
  localparam int PRESCALE = 4;
  localparam int HALF_W   = 4;
  localparam int BURST_W  = 3;
`ifdef LED_PWM_EN
  localparam int PWM_W    = 4;
`endif

  logic               CLK       = 1'b0;
  logic               RESET     = 1'b1;
  logic               iCfgValid = 1'b0;
  logic               vld_s     = 1'b0;
  logic [1:0]         iCfgCh    = '0;
  logic [1:0]         iCfgMode  = '0;
  logic [HALF_W-1:0]  iCfgHalf  = '0;
  logic [BURST_W-1:0] iCfgCount = '0;
`ifdef LED_PWM_EN
  logic [PWM_W-1:0]   iCfgDuty  = '1;
`endif
  logic               oCfgReady, rdy_s;
  logic [NCH-1:0]     oLED, oBusy;
  logic [2:0]         led_s, busy_s;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is described by its mode and the number of
  // ticks it has seen since its last write.
  int m_mode [NCH];
  int m_half [NCH];
  int m_cnt  [NCH];
  int m_t    [NCH];
  int m_duty [NCH];
  int edges = 0;
  bit m_rdy = 1'b0;

  led_pattern_ctrl #(
    .NCH(NCH), .PRESCALE(PRESCALE), .HALF_W(HALF_W), .BURST_W(BURST_W)
`ifdef LED_PWM_EN
    , .PWM_W(PWM_W)
`endif
  ) dut (
    .CLK(CLK), .RESET(RESET), .iCfgValid(iCfgValid), .iCfgCh(iCfgCh),
    .iCfgMode(iCfgMode), .iCfgHalf(iCfgHalf), .iCfgCount(iCfgCount),
`ifdef LED_PWM_EN
    .iCfgDuty(iCfgDuty),
`endif
    .oCfgReady(oCfgReady), .oLED(oLED), .oBusy(oBusy)
  );

  // Three-channel instance: channel number 3 is out of range here.
  led_pattern_ctrl #(
    .NCH(3), .PRESCALE(PRESCALE), .HALF_W(HALF_W), .BURST_W(BURST_W)
`ifdef LED_PWM_EN
    , .PWM_W(PWM_W)
`endif
  ) u_small (
    .CLK(CLK), .RESET(RESET), .iCfgValid(vld_s), .iCfgCh(iCfgCh),
    .iCfgMode(iCfgMode), .iCfgHalf(iCfgHalf), .iCfgCount(iCfgCount),
`ifdef LED_PWM_EN
    .iCfgDuty(iCfgDuty),
`endif
    .oCfgReady(rdy_s), .oLED(led_s), .oBusy(busy_s)
  );

  always #5 CLK = ~CLK;

  function automatic int lit_of(int ch);
    int ph;
    ph = (m_t[ch] / m_half[ch]) % 2;
    case (m_mode[ch])
      0:       return 0;
      1:       return 1;
      2:       return ph;
      default: return (m_cnt[ch] != 0 && m_t[ch] / (2 * m_half[ch]) < m_cnt[ch]) ? ph : 0;
    endcase
  endfunction

  function automatic bit busy_of(int ch);
    return m_mode[ch] == 3 && m_cnt[ch] != 0 && m_t[ch] / (2 * m_half[ch]) < m_cnt[ch];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0; m_half[c] = 1; m_cnt[c] = 0; m_t[c] = 0; m_duty[c] = 15;
    end
    edges = 0;
    m_rdy = 1'b0;
  endtask

  // One clock: advance the model with the inputs present at the edge, then check.
  task automatic step();
    logic [NCH-1:0] exp_led, exp_busy;
    bit tk;
    int pw;
    @(posedge CLK);
    exp_led  = '0;
    exp_busy = '0;
    if (RESET) begin
      model_reset();
    end else begin
      edges++;
      tk = (edges % PRESCALE) == 0;
      pw = (edges - 1) % 16;
      for (int c = 0; c < NCH; c++) begin
        exp_led[c] = (lit_of(c) != 0);
`ifdef LED_PWM_EN
        exp_led[c] = exp_led[c] && (m_duty[c] == 15 || pw < m_duty[c]);
`endif
      end
      for (int c = 0; c < NCH; c++) begin
        if (iCfgValid && m_rdy && int'(iCfgCh) == c) begin
          m_mode[c] = int'(iCfgMode);
          m_half[c] = (iCfgHalf == '0) ? 1 : int'(iCfgHalf);
          m_cnt[c]  = int'(iCfgCount);
          m_t[c]    = 0;
`ifdef LED_PWM_EN
          m_duty[c] = int'(iCfgDuty);
`endif
        end else if (tk) begin
          m_t[c]++;
        end
      end
      m_rdy = 1'b1;
      for (int c = 0; c < NCH; c++) exp_busy[c] = busy_of(c);
    end
    #1;
    chk("oLED", 32'(oLED), 32'(exp_led));
    chk("oBusy", 32'(oBusy), 32'(exp_busy));
    chk("oCfgReady", 32'(oCfgReady), 32'(m_rdy));
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic wr(int ch, int mode, int half, int cnt);
    iCfgValid = 1'b1;
    iCfgCh    = 2'(ch);
    iCfgMode  = 2'(mode);
    iCfgHalf  = HALF_W'(half);
    iCfgCount = BURST_W'(cnt);
    step();
    iCfgValid = 1'b0;
  endtask

`ifdef LED_PWM_EN
  task automatic set_duty(int d);
    iCfgDuty = PWM_W'(d);
  endtask
`endif

  initial begin
    model_reset();
    RESET = 1'b1;
    run(3);
    RESET = 1'b0;
    run(2);

    // Continuous blink, then a three-pulse burst, then a zero-count burst.
    wr(0, 2, 2, 0);
    run(40);
    wr(1, 3, 1, 3);
    run(36);
    wr(2, 3, 2, 0);
    run(8);

    // Switch ch0 to ON exactly on a tick while ch2 keeps blinking.
    wr(2, 2, 1, 0);
    run(5);
    while (((edges + 1) % PRESCALE) != 0) step();
    wr(0, 1, 3, 0);
    run(20);

    // Abort a running burst with a new mode.
    wr(1, 3, 2, 5);
    run(10);
    wr(1, 2, 1, 0);
    run(12);

`ifdef LED_PWM_EN
    set_duty(4);
    wr(3, 1, 1, 0);
    run(32);
    set_duty(0);
    wr(3, 1, 1, 0);
    run(20);
    set_duty(15);
    wr(3, 1, 1, 0);
    run(20);
`endif

    repeat (400) begin
      if ($urandom_range(0, 5) == 0) begin
`ifdef LED_PWM_EN
        set_duty(int'($urandom_range(0, 15)));
`endif
        wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      end else begin
        step();
      end
    end

    // Reset in the middle of activity.
    wr(0, 2, 1, 0);
    run(6);
    RESET = 1'b1;
    run(2);
    RESET = 1'b0;
    run(10);

    // Out-of-range channel on the three-channel instance is ignored.
    iCfgCh   = 2'd3;
    iCfgMode = 2'd1;
    vld_s    = 1'b1;
    step();
    vld_s    = 1'b0;
    step();
    chk("small_ignored_led", 32'(led_s), 32'h0);
    chk("small_ignored_busy", 32'(busy_s), 32'h0);
    iCfgCh   = 2'd2;
    vld_s    = 1'b1;
    step();
    vld_s    = 1'b0;
    step();
    chk("small_ch2_on", 32'(led_s), 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
